morse_key_timer: RTL and testbench
==================================

MORSE_KEY_TIMER -- requirements
Module: morse_key_timer

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 1000: clock cycles per Morse time unit (>=2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: stable cycles required before the filtered key changes (>=1).
REQ-003 SHALL have parameter CNT_W, default 16: duration counter width; must hold 7*UNIT_CYCLES.
REQ-004 SHALL have port Clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port Reset  input  1  reset; one clock, reset synchronous and active-high.
REQ-006 SHALL have port Key  input  1  raw asynchronous telegraph key, high = pressed.
REQ-007 SHALL have port Dot  output  1  one-cycle pulse: short press classified.
REQ-008 SHALL have port Dash  output  1  one-cycle pulse: long press classified.
REQ-009 SHALL have port EndSeq  output  1  one-cycle pulse: inter-character gap reached.
REQ-010 SHALL have port Space  output  1  one-cycle pulse: inter-word gap reached.
REQ-011 SHALL drive Dot, Dash, EndSeq and Space directly into morse_code_encoder, with all four registered.

Function
REQ-012 SHALL pass Key through a 2-flop synchronizer; the synchronized key, optionally debounced per REQ-028, is the filtered key (fk).
REQ-013 SHALL implement FSM states IDLE, PRESS, GAP_CHAR and GAP_WORD, plus counter cnt[CNT_W-1:0].
REQ-014 SHALL count cnt +1 per cycle in PRESS, GAP_CHAR and GAP_WORD, saturating at 7*UNIT_CYCLES, and clear cnt on every state transition.
REQ-015 SHALL, in IDLE, move to PRESS on fk=1; otherwise stay in IDLE with no output.
REQ-016 SHALL, in PRESS, on the first cycle fk=0, pulse Dot on the next cycle if cnt < 2*UNIT_CYCLES, else pulse Dash, and move to GAP_CHAR.
REQ-017 SHALL, in PRESS, keep a press held beyond 7 units as a Dash, with no timeout pulse.
REQ-018 SHALL, in GAP_CHAR, move to PRESS on fk=1 with no pulse; when cnt reaches 3*UNIT_CYCLES, pulse EndSeq and move to GAP_WORD.
REQ-019 SHALL, in GAP_WORD, move to PRESS on fk=1 with no pulse; when cnt reaches 7*UNIT_CYCLES (total gap 10 units), pulse Space and move to IDLE.
REQ-020 SHALL, when fk=1 and a gap threshold occur in the same cycle, give fk priority: move to PRESS and suppress the gap pulse.
REQ-021 SHALL assert at most one of Dot/Dash/EndSeq/Space in any cycle, each for exactly 1 cycle.
REQ-022 SHALL emit EndSeq at most once per gap and Space at most once per gap; Space is always preceded by EndSeq.
REQ-023 SHALL have a fixed latency from Key edge to fk edge of 2 cycles (macro off) or 2+DEBOUNCE_CYCLES cycles (macro on).

Reset
REQ-024 SHALL, while Reset=1, force state=IDLE, cnt=0, the synchronizer flops, fk and the debounce counter to 0, and all outputs to 0.
REQ-025 SHALL, on reset mid-press, emit no pulse; a key still held after reset is treated as a new press once fk rises.
REQ-026 SHALL, on reset mid-gap, discard any pending EndSeq or Space.

Configuration
REQ-027 SHALL compile the debounce filter in or out with macro MORSE_KEY_DEBOUNCE_EN.
REQ-028 SHALL, with MORSE_KEY_DEBOUNCE_EN defined, change fk only after the synchronized key differs from fk for DEBOUNCE_CYCLES consecutive cycles; any mismatch break restarts the count.
REQ-029 SHALL, without MORSE_KEY_DEBOUNCE_EN, set fk equal to the synchronizer output and instantiate no debounce counter.

Verification
(All scenarios use UNIT_CYCLES=10, DEBOUNCE_CYCLES=4.)
REQ-030 SHALL cover: Key high 12 cycles then low 40 cycles -> one Dot, then EndSeq 30 cycles after classification; no Space.
REQ-031 SHALL cover: Key high 25 cycles then low 120 cycles -> Dash, EndSeq at gap 30, Space at gap 100, state IDLE.
REQ-032 SHALL cover: Dot, gap 25, Dash (the "A" pattern) -> Dot, Dash, EndSeq in order, with no EndSeq between the two symbols.
REQ-033 SHALL cover, macro on: Key glitches high for 3 cycles -> no pulse; Key bounces 1-0-1 within 4 cycles, then held 30 -> exactly one Dash.
REQ-034 SHALL cover: Reset=1 for 1 cycle at cnt=15 of a press -> no Dot or Dash; after release, all outputs 0 and state IDLE.
REQ-035 SHALL cover: Key rises in the same cycle GAP_CHAR cnt hits 30 -> no EndSeq; state PRESS.

Source files
------------

// File: rtl/morse_key_timer.sv
// rtl/morse_key_timer.sv - telegraph key timer: classifies presses into Dot/Dash and gaps into EndSeq/Space.
// Optional debounce filter on the synchronized key is compiled in with MORSE_KEY_DEBOUNCE_EN.
module morse_key_timer #(
  parameter int UNIT_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Key,
  output logic Dot,
  output logic Dash,
  output logic EndSeq,
  output logic Space
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PRESS    = 2'd1;
  localparam logic [1:0] S_GAP_CHAR = 2'd2;
  localparam logic [1:0] S_GAP_WORD = 2'd3;

  localparam logic [CNT_W-1:0] DOT_LIMIT = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CHAR_LAST = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(7 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(7 * UNIT_CYCLES);

  if (UNIT_CYCLES < 2 || DEBOUNCE_CYCLES < 1 || CNT_W < 2 || CNT_W > 31 ||
      (7 * UNIT_CYCLES) > ((1 << CNT_W) - 1)) begin : g_param_check
    $error("morse_key_timer: illegal parameter combination");
  end

  logic sync1_q, sync2_q;
  logic fk;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= Key;
      sync2_q <= sync1_q;
    end
  end

`ifdef MORSE_KEY_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            fk_q, fk_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  // Any cycle where the synchronized key agrees with fk restarts the stability count.
  always_comb begin
    fk_d     = fk_q;
    db_cnt_d = '0;
    if (sync2_q != fk_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        fk_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fk_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      fk_q     <= fk_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign fk = fk_q;
`else
  assign fk = sync2_q;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             dot_q, dot_d;
  logic             dash_q, dash_d;
  logic             end_q, end_d;
  logic             space_q, space_d;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // A rising key always wins over a gap threshold reached in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    dot_d   = 1'b0;
    dash_d  = 1'b0;
    end_d   = 1'b0;
    space_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fk) begin
          state_d = S_PRESS;
        end
      end
      S_PRESS: begin
        if (!fk) begin
          state_d = S_GAP_CHAR;
          cnt_d   = '0;
          if (cnt_q < DOT_LIMIT) begin
            dot_d = 1'b1;
          end else begin
            dash_d = 1'b1;
          end
        end
      end
      S_GAP_CHAR: begin
        if (fk) begin
          state_d = S_PRESS;
          cnt_d   = '0;
        end else if (cnt_q == CHAR_LAST) begin
          state_d = S_GAP_WORD;
          cnt_d   = '0;
          end_d   = 1'b1;
        end
      end
      S_GAP_WORD: begin
        if (fk) begin
          state_d = S_PRESS;
          cnt_d   = '0;
        end else if (cnt_q == WORD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          space_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      end_q   <= 1'b0;
      space_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      end_q   <= end_d;
      space_q <= space_d;
    end
  end

  assign Dot    = dot_q;
  assign Dash   = dash_q;
  assign EndSeq = end_q;
  assign Space  = space_q;

endmodule

// File: tb/tb_morse_key_timer.sv
// tb/tb_morse_key_timer.sv - scoreboard bench for morse_key_timer with a run-length reference model.
module tb_morse_key_timer;

  localparam int U  = 10;
  localparam int DB = 4;

  logic Clk = 1'b0;
  logic Reset;
  logic Key;
  logic Dot, Dash, EndSeq, Space;

  always #5 Clk = ~Clk;

  morse_key_timer #(
    .UNIT_CYCLES    (U),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (16)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Key   (Key),
    .Dot   (Dot),
    .Dash  (Dash),
    .EndSeq(EndSeq),
    .Space (Space)
  );

  typedef struct {
    int         cyc;
    logic [3:0] kind;
  } ev_t;

  // kind bits: {Dot, Dash, EndSeq, Space}
  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  bit  rst_now  = 1'b0;

  // Reference model: filtered key is the key delayed two cycles (plus debounce),
  // then presses and gaps are classified by the lengths of fk runs.
  initial begin : model
    bit m_s1, m_fk, f;
    int mode, run_len;
    logic [3:0] k;
`ifdef MORSE_KEY_DEBOUNCE_EN
    bit m_s2, all_diff;
    bit hist[$];
    m_s2 = 1'b0;
`endif
    m_s1 = 1'b0; m_fk = 1'b0; mode = 0; run_len = 0;
    forever begin
      @(posedge Clk);
      cyc++;
      rst_now = Reset;
      if (Reset) begin
        m_s1 = 1'b0; m_fk = 1'b0; mode = 0; run_len = 0;
`ifdef MORSE_KEY_DEBOUNCE_EN
        m_s2 = 1'b0;
        hist.delete();
`endif
      end else begin
        f = m_fk;
        k = 4'b0000;
        if (f) begin
          if (mode != 1) begin
            mode = 1;
            run_len = 0;
          end
          run_len++;
        end else if (mode == 1) begin
          k = (run_len <= 2 * U) ? 4'b1000 : 4'b0100;
          mode = 2;
          run_len = 1;
        end else if (mode == 2) begin
          run_len++;
          if (run_len == 3 * U + 1) begin
            k = 4'b0010;
          end else if (run_len == 10 * U + 1) begin
            k = 4'b0001;
            mode = 0;
          end
        end
        if (k != 4'b0000) exp_q.push_back('{cyc, k});
`ifdef MORSE_KEY_DEBOUNCE_EN
        all_diff = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] == m_fk) all_diff = 1'b0;
        if (all_diff) m_fk = ~m_fk;
        m_s2 = m_s1;
        m_s1 = Key;
        hist.push_back(m_s2);
        if (hist.size() > DB) void'(hist.pop_front());
`else
        m_fk = m_s1;
        m_s1 = Key;
`endif
      end
    end
  end

  initial begin : monitor
    logic [3:0] got, expk;
    ev_t ev;
    forever begin
      @(negedge Clk);
      got  = {Dot, Dash, EndSeq, Space};
      expk = 4'b0000;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ev = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_pulse cycle=%0d kind=%b not seen", ev.cyc, ev.kind);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ev = exp_q.pop_front();
        expk = ev.kind;
      end
      if (got != 4'b0000 || expk != 4'b0000 || rst_now) begin
        checks++;
        if (got !== expk) begin
          failures++;
          $display("FAIL pulse cycle=%0d got {Dot,Dash,EndSeq,Space}=%b expected=%b", cyc, got, expk);
        end
      end
    end
  end

  task automatic seg(input bit v, input int n);
    Key = v;
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  function automatic int pick_len();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(1, 6);
      1:       return $urandom_range(8, 25);
      2:       return $urandom_range(18, 40);
      default: return $urandom_range(28, 110);
    endcase
  endfunction

  initial begin : stimulus
    Reset = 1'b1;
    Key   = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    seg(0, 5);

    seg(1, 12); seg(0, 140);                             // dot, EndSeq, later Space
    seg(1, 25); seg(0, 140);                             // dash, EndSeq, Space
    seg(1, 12); seg(0, 25); seg(1, 25); seg(0, 140);     // "A"
    seg(1, 20); seg(0, 40);                              // longest dot
    seg(1, 21); seg(0, 140);                             // shortest dash
    seg(1, 90); seg(0, 140);                             // held past 7 units
    seg(1, 3);  seg(0, 140);                             // short glitch
    seg(1, 1); seg(0, 1); seg(1, 30); seg(0, 140);       // bounce then hold
    seg(1, 17); Key = 1'b1; pulse_reset(); seg(1, 5); seg(0, 140);
    seg(1, 12); seg(0, 30); seg(1, 12); seg(0, 140);     // key rises on EndSeq threshold
    seg(1, 12); seg(0, 31); seg(1, 12); seg(0, 140);     // one cycle later: EndSeq fires
    seg(1, 12); seg(0, 100); seg(1, 12); seg(0, 140);    // key rises on Space threshold
    seg(1, 12); seg(0, 50); pulse_reset(); seg(0, 140);  // reset mid-gap

    for (int i = 0; i < 30; i++) begin
      seg(1, pick_len());
      seg(0, pick_len());
      if ($urandom_range(0, 9) == 0) pulse_reset();
    end
    seg(0, 150);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected count=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
